// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared DCT widths and sequencer state encoding
package dct_pkg;
  localparam int DCT_N     = 16;
  localparam int DCT_PAIRS = 8;
  localparam int IDX_W     = 4;
  localparam int PIX_W     = 8;
  localparam int COEF_W    = 18;
  localparam int COEF_FRAC = 8;

  typedef enum logic [1:0] {FILL, FEED, WAIT, DRAIN} seq_state_e;
endpackage

// File: rtl/dct_coef_buffer.sv
// rtl/dct_coef_buffer.sv - 16-entry coefficient register file, two write ports, B wins on collision
module dct_coef_buffer
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_a,
  input  logic [IDX_W-1:0]  addr_a,
  input  logic [COEF_W-1:0] data_a,
  input  logic              we_b,
  input  logic [IDX_W-1:0]  addr_b,
  input  logic [COEF_W-1:0] data_b,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [COEF_W-1:0] rd_data
);
  logic [COEF_W-1:0] mem_q [DCT_N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DCT_N; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DCT_N; i++) begin
        if (we_b && addr_b == IDX_W'(i))      mem_q[i] <= data_b;
        else if (we_a && addr_a == IDX_W'(i)) mem_q[i] <= data_a;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/dct_block_sequencer.sv
// rtl/dct_block_sequencer.sv - buffers a 16-pixel block, feeds mirrored pairs to the DCT core, reorders coefficients
module dct_block_sequencer
  import dct_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              dct_start,
  output logic [PIX_W-1:0]  dct_in_a,
  output logic [PIX_W-1:0]  dct_in_b,
  input  logic [COEF_W-1:0] dct_out_a,
  input  logic [COEF_W-1:0] dct_out_b,
  input  logic [IDX_W-1:0]  dct_idx_a,
  input  logic [IDX_W-1:0]  dct_idx_b,
  input  logic              dct_out_en,
  output logic              m_valid,
  output logic [COEF_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              timeout_err
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [4:0]        fill_cnt_q, fill_cnt_d;
  logic [2:0]        feed_cnt_q, feed_cnt_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [PIX_W-1:0]  in_buf_q [DCT_N];
  logic [COEF_W-1:0] rd_data;

  logic accept, full_next, feed_last, beat, last_beat, wait_expired, drain_hs, wait_live;

  assign accept       = s_valid && s_ready;
  // Full either already, or becoming full on this edge, so FEED follows the 16th sample directly.
  assign full_next    = (fill_cnt_q == 5'(DCT_N)) || (accept && fill_cnt_q == 5'(DCT_N - 1));
  assign feed_last    = (state_q == FEED) && (feed_cnt_q == 3'(DCT_PAIRS - 1));
  assign beat         = (state_q == WAIT) && dct_out_en;
  assign last_beat    = beat && (beat_cnt_q == 4'(DCT_PAIRS - 1));
  assign wait_expired = (state_q == WAIT) && (wait_cnt_q == WAIT_LAST) && !last_beat;
  assign drain_hs     = (state_q == DRAIN) && m_ready;
  assign wait_live    = (state_q == WAIT) && !last_beat && !wait_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (full_next) state_d = FEED;
      FEED:    if (feed_last) state_d = WAIT;
      WAIT: begin
        if (last_beat)         state_d = DRAIN;
        else if (wait_expired) state_d = full_next ? FEED : FILL;
      end
      DRAIN:   if (drain_hs && drain_cnt_q == 4'(DCT_N - 1)) state_d = full_next ? FEED : FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready   = (fill_cnt_q < 5'(DCT_N)) && (state_q != FEED);
    dct_start = 1'b0;
    dct_in_a  = '0;
    dct_in_b  = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_index   = '0;
    m_last    = 1'b0;
    if (state_q == FEED) begin
      dct_start = (feed_cnt_q == 3'd0);
      dct_in_a  = in_buf_q[{1'b0, feed_cnt_q}];
      dct_in_b  = in_buf_q[4'(DCT_N - 1) - {1'b0, feed_cnt_q}];
    end
    if (state_q == DRAIN) begin
      m_valid = 1'b1;
      m_data  = rd_data;
      m_index = drain_cnt_q;
      m_last  = (drain_cnt_q == 4'(DCT_N - 1));
    end
  end

  assign busy        = (state_q != FILL);
  assign timeout_err = timeout_err_q;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (feed_last)   fill_cnt_d = '0;
    else if (accept) fill_cnt_d = fill_cnt_q + 5'd1;
    feed_cnt_d    = (state_q == FEED) ? feed_cnt_q + 3'd1 : '0;
    beat_cnt_d    = wait_live ? beat_cnt_q + 4'(beat) : '0;
    wait_cnt_d    = wait_live ? wait_cnt_q + WAIT_W'(1) : '0;
    drain_cnt_d   = drain_hs ? drain_cnt_q + 4'd1 : drain_cnt_q;
    timeout_err_d = timeout_err_q || wait_expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt_q    <= '0;
      feed_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      fill_cnt_q    <= fill_cnt_d;
      feed_cnt_q    <= feed_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) in_buf_q[fill_cnt_q[3:0]] <= s_data;
  end

  dct_coef_buffer u_coef_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .we_a    (beat),
    .addr_a  (dct_idx_a),
    .data_a  (dct_out_a),
    .we_b    (beat),
    .addr_b  (dct_idx_b),
    .data_b  (dct_out_b),
    .rd_addr (drain_cnt_q),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb/tb_dct_block_sequencer.sv - directed self-checking bench for dct_block_sequencer
module tb_dct_block_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        dct_start;
  logic [7:0]  dct_in_a, dct_in_b;
  logic [17:0] dct_out_a, dct_out_b;
  logic [3:0]  dct_idx_a, dct_idx_b;
  logic        dct_out_en;
  logic        m_valid;
  logic [17:0] m_data;
  logic [3:0]  m_index;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  pix [16];
  logic [17:0] exp_res [16];
  logic [7:0]  spec_pix [16] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd17, 8'd19, 8'd21,
                                 8'd22, 8'd18, 8'd18, 8'd16, 8'd8, 8'd6, 8'd4, 8'd2};
  int tab_a [8] = '{0, 3, 1, 2, 7, 4, 6, 5};
  int tab_b [8] = '{8, 11, 9, 10, 15, 12, 14, 13};
  int dup_a [8] = '{0, 3, 1, 2, 7, 4, 6, 5};
  int dup_b [8] = '{8, 11, 1, 10, 15, 12, 14, 13};
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  dct_block_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .dct_start   (dct_start),
    .dct_in_a    (dct_in_a),
    .dct_in_b    (dct_in_b),
    .dct_out_a   (dct_out_a),
    .dct_out_b   (dct_out_b),
    .dct_idx_a   (dct_idx_a),
    .dct_idx_b   (dct_idx_b),
    .dct_out_en  (dct_out_en),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_index     (m_index),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s_valid    = 1'b0;
    s_data     = '0;
    dct_out_en = 1'b0;
    dct_out_a  = '0;
    dct_out_b  = '0;
    dct_idx_a  = '0;
    dct_idx_b  = '0;
    m_ready    = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},     32'(s_ready),     32'd1);
    check({tag, "_dct_start"},   32'(dct_start),   32'd0);
    check({tag, "_dct_in_a"},    32'(dct_in_a),    32'd0);
    check({tag, "_dct_in_b"},    32'(dct_in_b),    32'd0);
    check({tag, "_m_valid"},     32'(m_valid),     32'd0);
    check({tag, "_m_data"},      32'(m_data),      32'd0);
    check({tag, "_m_index"},     32'(m_index),     32'd0);
    check({tag, "_m_last"},      32'(m_last),      32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic gen_pix(input int seed);
    for (int i = 0; i < 16; i++) pix[i] = 8'((seed * 53 + i * 29 + 7) & 255);
  endtask

  task automatic fill_block();
    for (int i = 0; i < 16; i++) begin
      check("s_ready_fill", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = pix[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic check_feed();
    for (int k = 0; k < 8; k++) begin
      check("dct_start",    32'(dct_start), 32'(k == 0));
      check("dct_in_a",     32'(dct_in_a),  32'(pix[k]));
      check("dct_in_b",     32'(dct_in_b),  32'(pix[15 - k]));
      check("s_ready_feed", 32'(s_ready),   32'd0);
      @(negedge clk);
    end
    check("s_ready_wait",   32'(s_ready),   32'd1);
    check("dct_start_wait", 32'(dct_start), 32'd0);
    check("dct_in_a_wait",  32'(dct_in_a),  32'd0);
    check("busy_wait",      32'(busy),      32'd1);
  endtask

  task automatic wait_and_drain(input int gap, input bit with_next, input bit bp, input bit dup,
                                input int mul, input int add, input int boff, input int stop_at);
    int cyc, nbeat, sent, got, dcyc, ia, ib, va, vb;
    cyc = 0; nbeat = 0; sent = 0; got = 0; dcyc = 0;
    while (got < stop_at && cyc < 300) begin
      check("m_valid",    32'(m_valid), 32'(nbeat == 8));
      check("busy_wd",    32'(busy),    32'd1);
      check("s_ready_wd", 32'(s_ready), 32'(sent < 16));
      if (m_valid) begin
        check("m_index", 32'(m_index), 32'(got));
        check("m_data",  32'(m_data),  32'(exp_res[got]));
        check("m_last",  32'(m_last),  32'(got == 15));
      end
      dct_out_en = 1'b0;
      if (cyc >= gap && nbeat < 8) begin
        ia = dup ? dup_a[nbeat] : tab_a[nbeat];
        ib = dup ? dup_b[nbeat] : tab_b[nbeat];
        va = ia * mul + add;
        vb = ib * mul + add + boff;
        dct_out_en  = 1'b1;
        dct_idx_a   = 4'(ia);
        dct_idx_b   = 4'(ib);
        dct_out_a   = 18'(va);
        dct_out_b   = 18'(vb);
        exp_res[ia] = 18'(va);
        exp_res[ib] = 18'(vb);
        nbeat++;
      end
      s_valid = with_next && (sent < 16);
      if (sent < 16) s_data = pix[sent];
      if (s_valid && s_ready) sent++;
      m_ready = bp ? bp_pat[dcyc % 4] : 1'b1;
      if (m_valid) begin
        if (m_ready) got++;
        dcyc++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_count", 32'(got), 32'(stop_at));
    idle_inputs();
  endtask

  task automatic timeout_case();
    int sent;
    sent = 0;
    for (int c = 0; c < 64; c++) begin
      check("to_m_valid", 32'(m_valid),     32'd0);
      check("to_err_low", 32'(timeout_err), 32'd0);
      s_valid = (sent < 16);
      if (sent < 16) s_data = pix[sent];
      if (s_valid && s_ready) sent++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_m_valid_end", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Block A: mirrored feed of the reference stream, then reorder of indexed beats.
    for (int i = 0; i < 16; i++) pix[i] = spec_pix[i];
    fill_block();
    check_feed();
    wait_and_drain(3, 1'b0, 1'b0, 1'b0, 256, 0, 0, 16);
    check("busy_after_a", 32'(busy), 32'd0);

    // Spurious beat during FILL aimed at the index block B leaves unwritten.
    dct_out_en = 1'b1;
    dct_idx_a  = 4'd9;
    dct_idx_b  = 4'd9;
    dct_out_a  = 18'd12345;
    dct_out_b  = 18'd12345;
    @(negedge clk);
    idle_inputs();
    check("spur_busy",    32'(busy),    32'd0);
    check("spur_m_valid", 32'(m_valid), 32'd0);

    // Block B: duplicate index (B wins), stale index 9, backpressure, block C streams in.
    gen_pix(1);
    fill_block();
    check_feed();
    gen_pix(2);
    wait_and_drain(5, 1'b1, 1'b1, 1'b1, -256, -1, 3, 16);
    check_feed();

    // Block C never gets beats; block D streams in while waiting.
    gen_pix(3);
    timeout_case();
    check_feed();
    wait_and_drain(2, 1'b0, 1'b0, 1'b0, 256, 7, 0, 16);
    check("err_sticky", 32'(timeout_err), 32'd1);
    check("busy_after_d", 32'(busy), 32'd0);

    // Block E: asynchronous reset while index 5 is presented.
    gen_pix(4);
    fill_block();
    check_feed();
    wait_and_drain(1, 1'b0, 1'b0, 1'b0, 256, 0, 0, 5);
    check("pre_reset_valid", 32'(m_valid), 32'd1);
    check("pre_reset_idx",   32'(m_index), 32'd5);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Block F: fresh block after reset.
    gen_pix(5);
    fill_block();
    check_feed();
    wait_and_drain(4, 1'b0, 1'b0, 1'b0, 256, 0, 0, 16);
    check("busy_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
